// File: rtl/tt6581_pkg.sv
// Shared constants and types for the tt6581 arithmetic blocks.
package tt6581_pkg;

    localparam int unsigned MULT_A_W = 24;
    localparam int unsigned MULT_B_W = 16;
    localparam int unsigned MULT_P_W = MULT_A_W + MULT_B_W;

    typedef enum logic [1:0] {
        MULT_IDLE,
        MULT_BUSY,
        MULT_DONE
    } mult_state_e;

endpackage

// File: rtl/seq_mult_booth_enc.sv
// Radix-4 Booth recoder: triplet {b[2k+1], b[2k], b[2k-1]} -> {neg, two, zero}.
// Present only when SEQ_MULT_BOOTH_R4_EN is defined.
`ifdef SEQ_MULT_BOOTH_R4_EN
module seq_mult_booth_enc (
    input  logic [2:0] triplet,
    output logic       neg_c,
    output logic       two_c,
    output logic       zero_c
);

    // 000/111 -> 0, 001/010 -> +a, 011 -> +2a, 100 -> -2a, 101/110 -> -a
    always_comb begin
        neg_c  = triplet[2] & ~(triplet[1] & triplet[0]);
        two_c  = (triplet == 3'b011) | (triplet == 3'b100);
        zero_c = (triplet == 3'b000) | (triplet == 3'b111);
    end

endmodule
`endif

// File: rtl/seq_mult.sv
// Shared sequential signed multiplier, start/ready handshake, exact full-width product.
// Macro SEQ_MULT_BOOTH_R4_EN selects radix-4 Booth (B_WIDTH/2 steps) over radix-2 (B_WIDTH steps).
module seq_mult
    import tt6581_pkg::*;
#(
    parameter int unsigned A_WIDTH = MULT_A_W,
    parameter int unsigned B_WIDTH = MULT_B_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [A_WIDTH-1:0]         a_i,
    input  logic [B_WIDTH-1:0]         b_i,
    output logic                       busy_o,
    output logic                       ready_o,
    output logic [A_WIDTH+B_WIDTH-1:0] prod_o
);

    localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;
`ifdef SEQ_MULT_BOOTH_R4_EN
    localparam int unsigned ITER    = B_WIDTH / 2;
    localparam int unsigned SHIFT   = 2;
`else
    localparam int unsigned ITER    = B_WIDTH;
    localparam int unsigned SHIFT   = 1;
`endif
    localparam int unsigned CNT_W   = $clog2(ITER + 1);

    mult_state_e        state_q, state_d;
    logic               accept_c, step_c, last_c;
    logic [P_WIDTH-1:0] a_sh_q;
    logic [B_WIDTH-1:0] b_q;
    logic [P_WIDTH-1:0] acc_q, acc_nxt;
    logic [CNT_W-1:0]   cnt_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MULT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MULT_IDLE: if (start_i) state_d = MULT_BUSY;
            MULT_BUSY: if (last_c)  state_d = MULT_DONE;
            MULT_DONE: state_d = start_i ? MULT_BUSY : MULT_IDLE;
            default:   state_d = MULT_IDLE;
        endcase
    end

    // Control decode; start while BUSY is deliberately dropped
    always_comb begin
        accept_c = start_i && ((state_q == MULT_IDLE) || (state_q == MULT_DONE));
        step_c   = (state_q == MULT_BUSY);
        last_c   = step_c && (cnt_q == CNT_W'(ITER - 1));
    end

`ifdef SEQ_MULT_BOOTH_R4_EN
    logic               b_prev_q;
    logic               enc_neg, enc_two, enc_zero;
    logic [P_WIDTH-1:0] pp;

    seq_mult_booth_enc u_enc (
        .triplet ({b_q[1], b_q[0], b_prev_q}),
        .neg_c   (enc_neg),
        .two_c   (enc_two),
        .zero_c  (enc_zero)
    );

    // Partial product 0, a or 2a at the current alignment, then add or subtract
    always_comb begin
        pp      = enc_zero ? '0 : (enc_two ? (a_sh_q << 1) : a_sh_q);
        acc_nxt = enc_neg ? (acc_q - pp) : (acc_q + pp);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            b_prev_q <= 1'b0;
        end else if (accept_c) begin
            b_prev_q <= 1'b0;
        end else if (step_c) begin
            b_prev_q <= b_q[1];
        end
    end
`else
    logic [P_WIDTH-1:0] addend;

    // The b sign bit carries weight -2^(B_WIDTH-1), so the final step subtracts
    always_comb begin
        addend  = b_q[0] ? a_sh_q : '0;
        acc_nxt = last_c ? (acc_q - addend) : (acc_q + addend);
    end
`endif

    // Operand, accumulator and step counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sh_q <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (accept_c) begin
            a_sh_q <= P_WIDTH'($signed(a_i));
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (step_c) begin
            a_sh_q <= a_sh_q << SHIFT;
            b_q    <= b_q >> SHIFT;
            acc_q  <= acc_nxt;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // Registered outputs; prod_o only moves on the edge that raises ready_o
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o  <= 1'b0;
            ready_o <= 1'b0;
            prod_o  <= '0;
        end else begin
            busy_o  <= (state_d == MULT_BUSY);
            ready_o <= (state_d == MULT_DONE);
            if (last_c) begin
                prod_o <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed corner cases plus randomized operands
// against a plain a*b reference. Build with and without SEQ_MULT_BOOTH_R4_EN.
module tb_seq_mult;

    localparam int unsigned AW = 24;
    localparam int unsigned BW = 16;
    localparam int unsigned PW = AW + BW;
`ifdef SEQ_MULT_BOOTH_R4_EN
    localparam int ITER = BW / 2;
`else
    localparam int ITER = BW;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] a_in;
    logic [BW-1:0] b_in;
    logic          busy;
    logic          ready;
    logic [PW-1:0] prod;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint held;

    seq_mult dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a_in),
        .b_i     (b_in),
        .busy_o  (busy),
        .ready_o (ready),
        .prod_o  (prod)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint prod_s();
        return longint'($signed(prod));
    endfunction

    // Present a one-cycle start; returns #1 after the accepting edge (BUSY cycle 1)
    task automatic issue(input longint a, input longint b);
        start = 1'b1;
        a_in  = AW'(a);
        b_in  = BW'(b);
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = AW'($urandom);
        b_in  = BW'($urandom);
    endtask

    // Follow an operation from BUSY cycle n0 to the DONE cycle (cycle ITER+1)
    task automatic finish_op(input string tag, input int n0, input longint exp);
        int busy_cnt = 0;
        int ready_at = 0;
        for (int n = n0; n <= ITER + 1; n++) begin
            if (n > n0) begin
                @(posedge clk); #1;
            end
            if (busy) busy_cnt++;
            if (ready && ready_at == 0) ready_at = n;
            if (n == ITER) check({tag, " hold"}, prod_s(), held);
        end
        check({tag, " ready_at"}, longint'(ready_at), longint'(ITER + 1));
        check({tag, " busy_cycles"}, longint'(busy_cnt), longint'(ITER - n0 + 1));
        check({tag, " prod"}, prod_s(), exp);
        held = exp;
    endtask

    // Idle cycles: no ready pulse, product held
    task automatic idle_check(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        check({tag, " no_ready"}, longint'(pulses), 0);
        check({tag, " held"}, prod_s(), held);
    endtask

    function automatic longint pick_a();
        logic signed [AW-1:0] v;
        v = AW'($urandom);
        case ($urandom_range(0, 7))
            0: v = {1'b1, {(AW-1){1'b0}}};
            1: v = {1'b0, {(AW-1){1'b1}}};
            2: v = '0;
            3: v = '1;
            default: ;
        endcase
        return longint'(v);
    endfunction

    function automatic longint pick_b();
        logic signed [BW-1:0] v;
        v = BW'($urandom);
        case ($urandom_range(0, 7))
            0: v = {1'b1, {(BW-1){1'b0}}};
            1: v = {1'b0, {(BW-1){1'b1}}};
            2: v = '0;
            3: v = '1;
            default: ;
        endcase
        return longint'(v);
    endfunction

    initial begin
        longint ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        held  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", longint'(busy), 0);
        check("rst ready", longint'(ready), 0);
        check("rst prod", prod_s(), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(1, 1);
        finish_op("basic", 1, 1);
        @(posedge clk); #1;
        check("basic single_pulse", longint'(ready), 0);
        check("basic busy_after", longint'(busy), 0);

        issue(-8388608, -32768);
        finish_op("min_min", 1, 64'sd274877906944);
        issue(8388607, -32768);
        finish_op("max_min", 1, -64'sd274877874176);
        @(posedge clk); #1;

        issue(4096, 16384);
        finish_op("filter", 1, 67108864);
        check("filter slice", longint'(prod[38:15]), 2048);
        @(posedge clk); #1;

        issue(3, 5);
        start = 1'b1;
        a_in  = AW'(7);
        b_in  = BW'(7);
        @(posedge clk); #1;
        start = 1'b0;
        finish_op("busy_start", 2, 15);

        issue(-2, 9);
        finish_op("b2b", 1, -18);
        idle_check("b2b idle", ITER + 2);

        issue(100, 200);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", longint'(busy), 0);
        check("midrst ready", longint'(ready), 0);
        check("midrst prod", prod_s(), 0);
        held = 0;
        idle_check("midrst idle", ITER + 2);
        issue(5, -1);
        finish_op("post_rst", 1, -5);

        for (int k = 0; k < 60; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) idle_check("rand gap", gap);
            ra = pick_a();
            rb = pick_b();
            issue(ra, rb);
            finish_op("rand", 1, ra * rb);
        end
        idle_check("final", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
